// File: rtl/soc_addr_decoder.sv
// ---------------------------------------------------------------------------
// soc_addr_decoder
//   AXI address decoder with a built-in decode-error slave.
//   Mapped AW/AR requests are forwarded combinationally (sel one-hot + valid,
//   ready passed back). Unmapped requests are absorbed by two small FSMs that
//   return DECERR: the read side emits ar_len+1 R beats, the write side
//   drains the W burst and then returns one B response.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   aw_* / ar_*              upstream address channels
//   aw_sel_o / ar_sel_o      one-hot rule select (all-zero when unmapped)
//   slv_aw_* / slv_ar_*      valid/ready toward the selected downstream slave
//   err_w_* / err_b_*        W drain and B response of the error slave
//   err_r_*                  R response of the error slave
//   dec_err_cnt_o            saturating count of accepted unmapped requests
// ---------------------------------------------------------------------------

// Single address-rule comparator. The limit is formed one bit wider than the
// address so a rule ending exactly at the top of the address space does not wrap.
module soc_addr_rule_match #(
    parameter int unsigned          AddrWidth = 64,
    parameter logic [AddrWidth-1:0] Base      = '0,
    parameter logic [AddrWidth-1:0] Length    = '0,
    parameter bit                   Enable    = 1'b1
) (
    input  logic [AddrWidth-1:0] addr,
    output logic                 hit
);
    logic [AddrWidth:0] base_ext;
    logic [AddrWidth:0] limit_ext;
    logic [AddrWidth:0] addr_ext;
    logic               len_nz;

    assign base_ext  = {1'b0, Base};
    assign limit_ext = {1'b0, Base} + {1'b0, Length};
    assign addr_ext  = {1'b0, addr};
    assign len_nz    = (Length != '0);
    assign hit       = Enable && len_nz && (addr_ext >= base_ext) && (addr_ext < limit_ext);
endmodule

module soc_addr_decoder #(
    parameter int unsigned                        NrRules    = 10,
    parameter int unsigned                        AddrWidth  = 64,
    parameter int unsigned                        IdWidth    = 4,
    parameter logic [NrRules-1:0][AddrWidth-1:0]  AddrBase   = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0]  AddrLength = '0,
    parameter logic [NrRules-1:0]                 ValidRule  = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // AW
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [IdWidth-1:0]   aw_id_i,
    // AR
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    // forward
    output logic [NrRules-1:0]   aw_sel_o,
    output logic                 slv_aw_valid_o,
    input  logic                 slv_aw_ready_i,
    output logic [NrRules-1:0]   ar_sel_o,
    output logic                 slv_ar_valid_o,
    input  logic                 slv_ar_ready_i,
    // error write
    input  logic                 err_w_valid_i,
    input  logic                 err_w_last_i,
    output logic                 err_w_ready_o,
    output logic                 err_b_valid_o,
    input  logic                 err_b_ready_i,
    output logic [IdWidth-1:0]   err_b_id_o,
    output logic [1:0]           err_b_resp_o,
    // error read
    output logic                 err_r_valid_o,
    input  logic                 err_r_ready_i,
    output logic [IdWidth-1:0]   err_r_id_o,
    output logic                 err_r_last_o,
    output logic [1:0]           err_r_resp_o,
    // statistics
    output logic [15:0]          dec_err_cnt_o
);
    localparam logic [1:0] DecErr = 2'b11;

    typedef enum logic       {RD_IDLE, RD_RESP} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_DRAIN, WR_BRESP} wr_state_e;

    // ---------------------------------------------------------------- decode
    logic [NrRules-1:0] aw_hit, ar_hit;

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        soc_addr_rule_match #(
            .AddrWidth (AddrWidth),
            .Base      (AddrBase[g]),
            .Length    (AddrLength[g]),
            .Enable    (ValidRule[g])
        ) u_aw (
            .addr (aw_addr_i),
            .hit  (aw_hit[g])
        );
        soc_addr_rule_match #(
            .AddrWidth (AddrWidth),
            .Base      (AddrBase[g]),
            .Length    (AddrLength[g]),
            .Enable    (ValidRule[g])
        ) u_ar (
            .addr (ar_addr_i),
            .hit  (ar_hit[g])
        );
    end

    // Overlapping rules: lowest index wins.
    logic aw_found, ar_found;
    always_comb begin
        aw_sel_o = '0;
        ar_sel_o = '0;
        aw_found = 1'b0;
        ar_found = 1'b0;
        for (int i = 0; i < NrRules; i++) begin
            if (aw_hit[i] && !aw_found) begin
                aw_sel_o[i] = 1'b1;
                aw_found    = 1'b1;
            end
            if (ar_hit[i] && !ar_found) begin
                ar_sel_o[i] = 1'b1;
                ar_found    = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- state
    rd_state_e          rd_state_q, rd_state_d;
    wr_state_e          wr_state_q, wr_state_d;
    logic [7:0]         rd_beat_q, rd_beat_d;
    logic [7:0]         rd_len_q;
    logic [IdWidth-1:0] rd_id_q, wr_id_q;

    logic aw_mapped, ar_mapped;
    logic aw_stall, ar_stall;
    logic aw_err_acc, ar_err_acc;
    logic rd_idle, wr_idle;

    assign aw_mapped = |aw_sel_o;
    assign ar_mapped = |ar_sel_o;
    assign rd_idle   = (rd_state_q == RD_IDLE);
    assign wr_idle   = (wr_state_q == WR_IDLE);

    // Hold back a mapped request sharing an ID with an outstanding error
    // response, otherwise its response could overtake the DECERR.
    assign ar_stall = !rd_idle && (ar_id_i == rd_id_q);
    assign aw_stall = !wr_idle && (aw_id_i == wr_id_q);

    assign slv_ar_valid_o = ar_valid_i && ar_mapped && !ar_stall;
    assign slv_aw_valid_o = aw_valid_i && aw_mapped && !aw_stall;
    assign ar_ready_o     = ar_mapped ? (slv_ar_ready_i && !ar_stall) : rd_idle;
    assign aw_ready_o     = aw_mapped ? (slv_aw_ready_i && !aw_stall) : wr_idle;

    assign ar_err_acc = ar_valid_i && !ar_mapped && rd_idle;
    assign aw_err_acc = aw_valid_i && !aw_mapped && wr_idle;

    assign err_r_id_o   = rd_id_q;
    assign err_r_resp_o = DecErr;
    assign err_b_id_o   = wr_id_q;
    assign err_b_resp_o = DecErr;

    // ---------------------------------------------------------------- read FSM
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_beat_d     = rd_beat_q;
        err_r_valid_o = 1'b0;
        err_r_last_o  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_err_acc) begin
                    rd_state_d = RD_RESP;
                    rd_beat_d  = '0;
                end
            end
            RD_RESP: begin
                err_r_valid_o = 1'b1;
                err_r_last_o  = (rd_beat_q == rd_len_q);
                if (err_r_ready_i) begin
                    if (err_r_last_o) begin
                        rd_state_d = RD_IDLE;
                        rd_beat_d  = '0;
                    end else begin
                        rd_beat_d  = rd_beat_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= RD_IDLE;
            rd_beat_q  <= '0;
            rd_len_q   <= '0;
            rd_id_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_beat_q  <= rd_beat_d;
            if (ar_err_acc) begin
                rd_id_q  <= ar_id_i;
                rd_len_q <= ar_len_i;
            end
        end
    end

    // ---------------------------------------------------------------- write FSM
    always_comb begin
        wr_state_d    = wr_state_q;
        err_w_ready_o = 1'b0;
        err_b_valid_o = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_err_acc) wr_state_d = WR_DRAIN;
            end
            WR_DRAIN: begin
                err_w_ready_o = 1'b1;
                if (err_w_valid_i && err_w_last_i) wr_state_d = WR_BRESP;
            end
            WR_BRESP: begin
                err_b_valid_o = 1'b1;
                if (err_b_ready_i) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= WR_IDLE;
            wr_id_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_err_acc) wr_id_q <= aw_id_i;
        end
    end

    // ---------------------------------------------------------------- counter
    // Both channels can accept an unmapped request in the same cycle, so the
    // sum is formed one bit wide to detect overflow and clamp.
    logic [16:0] cnt_sum;
    assign cnt_sum = {1'b0, dec_err_cnt_o} + {16'd0, ar_err_acc} + {16'd0, aw_err_acc};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dec_err_cnt_o <= '0;
        else         dec_err_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
endmodule

// File: tb/tb_soc_addr_decoder.sv
// ---------------------------------------------------------------------------
// tb_soc_addr_decoder
//   Self-checking bench for soc_addr_decoder. Expected R beats and B
//   responses are queued when an unmapped request is issued and popped as the
//   error slave produces them. Inputs change on the falling edge; outputs are
//   sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_soc_addr_decoder;
    localparam int NR = 6;
    localparam int AW = 64;
    localparam int IW = 4;

    // rule 0: DRAM, rule 1: boot ROM, rule 2: overlaps DRAM (loses to 0),
    // rule 3: disabled, rule 4: top of address space, rule 5: zero length
    localparam logic [NR-1:0][AW-1:0] BASE = {
        64'h0000_0000_6000_0000, 64'hFFFF_FFFF_FFFF_F000, 64'h0000_0000_5000_0000,
        64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_8000_0000};
    localparam logic [NR-1:0][AW-1:0] LEN = {
        64'h0, 64'h1000, 64'h1000, 64'h1000, 64'h1000, 64'h0000_0000_4000_0000};
    localparam logic [NR-1:0] VALID = 6'b110111;

    logic          clk, rst_n;
    logic          aw_valid, aw_ready, ar_valid, ar_ready;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [IW-1:0] aw_id, ar_id;
    logic [7:0]    ar_len;
    logic [NR-1:0] aw_sel, ar_sel;
    logic          slv_aw_valid, slv_aw_ready, slv_ar_valid, slv_ar_ready;
    logic          err_w_valid, err_w_last, err_w_ready, err_b_valid, err_b_ready;
    logic [IW-1:0] err_b_id, err_r_id;
    logic [1:0]    err_b_resp, err_r_resp;
    logic          err_r_valid, err_r_ready, err_r_last;
    logic [15:0]   cnt;

    soc_addr_decoder #(
        .NrRules(NR), .AddrWidth(AW), .IdWidth(IW),
        .AddrBase(BASE), .AddrLength(LEN), .ValidRule(VALID)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr), .aw_id_i(aw_id),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_id_i(ar_id),
        .ar_len_i(ar_len),
        .aw_sel_o(aw_sel), .slv_aw_valid_o(slv_aw_valid), .slv_aw_ready_i(slv_aw_ready),
        .ar_sel_o(ar_sel), .slv_ar_valid_o(slv_ar_valid), .slv_ar_ready_i(slv_ar_ready),
        .err_w_valid_i(err_w_valid), .err_w_last_i(err_w_last), .err_w_ready_o(err_w_ready),
        .err_b_valid_o(err_b_valid), .err_b_ready_i(err_b_ready), .err_b_id_o(err_b_id),
        .err_b_resp_o(err_b_resp),
        .err_r_valid_o(err_r_valid), .err_r_ready_i(err_r_ready), .err_r_id_o(err_r_id),
        .err_r_last_o(err_r_last), .err_r_resp_o(err_r_resp),
        .dec_err_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic          last;
        logic [1:0]    resp;
    } rbeat_t;

    rbeat_t        exp_r[$];
    logic [IW-1:0] exp_b[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    logic [15:0]   exp_cnt = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_r(input logic [IW-1:0] id, input int len);
        for (int b = 0; b <= len; b++) exp_r.push_back('{id: id, last: (b == len), resp: 2'b11});
    endtask

    // Accept an unmapped AR; entered and left just after a falling edge.
    task automatic issue_ar_err(input logic [IW-1:0] id, input logic [7:0] len);
        ar_addr  = 64'h5000_0000;
        ar_id    = id;
        ar_len   = len;
        ar_valid = 1'b1;
        #1;
        chk("ar_err_ready", ar_ready, 1'b1);
        chk("ar_err_fwd", slv_ar_valid, 1'b0);
        push_r(id, int'(len));
        exp_cnt++;
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    // Consume up to n R beats against the queue, bounded by a cycle budget.
    task automatic drain_r(input int n);
        int     got   = 0;
        int     guard = 0;
        rbeat_t e;
        while (got < n && guard < 50) begin
            err_r_ready = 1'b1;
            #1;
            if (err_r_valid) begin
                if (exp_r.size() == 0) begin
                    chk("r_extra_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_r.pop_front();
                    chk("r_id", err_r_id, e.id);
                    chk("r_last", err_r_last, e.last);
                    chk("r_resp", err_r_resp, e.resp);
                end
                got++;
            end
            guard++;
            @(negedge clk);
        end
        if (got < n) chk("r_timeout", got, n);
        err_r_ready = 1'b0;
    endtask

    logic [AW-1:0] addr_tab[9] = '{64'h8000_1000, 64'h0FFF, 64'h1000, 64'h5000_0010,
                                   64'h6000_0000, 64'hBFFF_FFFF, 64'hC000_0000,
                                   64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF};
    logic [NR-1:0] sel_tab[9]  = '{6'b000001, 6'b000010, 6'b000000, 6'b000000,
                                   6'b000000, 6'b000001, 6'b000000, 6'b010000, 6'b000000};

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        logic [IW-1:0] eb;
        int            guard;
        clk = 0; rst_n = 0;
        aw_valid = 0; aw_addr = '0; aw_id = '0;
        ar_valid = 0; ar_addr = '0; ar_id = '0; ar_len = '0;
        slv_aw_ready = 0; slv_ar_ready = 0;
        err_w_valid = 0; err_w_last = 0; err_b_ready = 0; err_r_ready = 0;
        #1;
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_r_valid", err_r_valid, 1'b0);
        chk("rst_w_ready", err_w_ready, 1'b0);
        chk("rst_b_valid", err_b_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        // decode table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            aw_addr = addr_tab[i];
            ar_addr = addr_tab[i];
            #1;
            chk("aw_sel", aw_sel, sel_tab[i]);
            chk("ar_sel", ar_sel, sel_tab[i]);
        end

        // mapped pass-through, zero latency
        @(negedge clk);
        ar_addr = 64'h8000_1000; ar_id = 1; ar_valid = 1; slv_ar_ready = 0;
        aw_addr = 64'h0000_0100; aw_id = 1; aw_valid = 1; slv_aw_ready = 0;
        #1;
        chk("ar_fwd_valid", slv_ar_valid, 1'b1);
        chk("ar_fwd_ready0", ar_ready, 1'b0);
        chk("aw_fwd_valid", slv_aw_valid, 1'b1);
        chk("aw_fwd_ready0", aw_ready, 1'b0);
        slv_ar_ready = 1; slv_aw_ready = 1;
        #1;
        chk("ar_fwd_ready1", ar_ready, 1'b1);
        chk("aw_fwd_ready1", aw_ready, 1'b1);
        @(negedge clk);
        ar_valid = 0; aw_valid = 0;
        #1;
        chk("ar_fwd_idle", slv_ar_valid, 1'b0);
        chk("cnt_after_mapped", cnt, exp_cnt);

        // unmapped AR, id 3 len 3, with same-ID stall and other-ID bypass
        @(negedge clk);
        issue_ar_err(4'd3, 8'd3);
        #1;
        chk("cnt_ar", cnt, exp_cnt);
        chk("r_valid_held", err_r_valid, 1'b1);
        ar_addr = 64'h8000_1000; ar_id = 3; ar_valid = 1; slv_ar_ready = 1;
        #1;
        chk("stall_same_id_valid", slv_ar_valid, 1'b0);
        chk("stall_same_id_ready", ar_ready, 1'b0);
        ar_id = 4;
        #1;
        chk("pass_other_id_valid", slv_ar_valid, 1'b1);
        chk("pass_other_id_ready", ar_ready, 1'b1);
        ar_addr = 64'h5000_0000;
        #1;
        chk("unmapped_busy_ready", ar_ready, 1'b0);
        ar_valid = 0;
        @(negedge clk);
        #1;
        chk("r_stable_valid", err_r_valid, 1'b1);
        chk("r_stable_id", err_r_id, 4'd3);
        chk("r_stable_last", err_r_last, 1'b0);
        drain_r(4);
        ar_addr = 64'h8000_1000; ar_id = 3; ar_valid = 1;
        #1;
        chk("stall_released", slv_ar_valid, 1'b1);
        chk("r_idle_after", err_r_valid, 1'b0);
        ar_valid = 0;

        // single-beat read error
        @(negedge clk);
        issue_ar_err(4'd7, 8'd0);
        drain_r(1);
        chk("r_queue_empty", exp_r.size(), 0);

        // unmapped AW, id 5, 3 W beats, B back-pressured 4 cycles
        @(negedge clk);
        aw_addr = 64'h5000_0000; aw_id = 5; aw_valid = 1;
        #1;
        chk("aw_err_ready", aw_ready, 1'b1);
        chk("aw_err_fwd", slv_aw_valid, 1'b0);
        exp_b.push_back(4'd5);
        exp_cnt++;
        @(negedge clk);
        aw_addr = 64'h8000_0000; aw_id = 5; slv_aw_ready = 1;
        #1;
        chk("aw_stall_same_id", slv_aw_valid, 1'b0);
        aw_id = 6;
        #1;
        chk("aw_pass_other_id", slv_aw_valid, 1'b1);
        aw_valid = 0;
        chk("cnt_aw", cnt, exp_cnt);
        for (int b = 0; b < 3; b++) begin
            err_w_valid = 1; err_w_last = (b == 2);
            #1;
            chk("w_ready", err_w_ready, 1'b1);
            chk("b_early", err_b_valid, 1'b0);
            @(negedge clk);
        end
        err_w_valid = 0; err_w_last = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("b_hold_valid", err_b_valid, 1'b1);
            chk("b_hold_id", err_b_id, exp_b[0]);
            chk("b_hold_resp", err_b_resp, 2'b11);
            @(negedge clk);
        end
        err_b_ready = 1;
        #1;
        eb = exp_b.pop_front();
        chk("b_id", err_b_id, eb);
        @(negedge clk);
        err_b_ready = 0;
        #1;
        chk("b_single", err_b_valid, 1'b0);
        chk("w_idle", err_w_ready, 1'b0);

        // reset in the middle of a 4-beat read error
        @(negedge clk);
        issue_ar_err(4'd2, 8'd3);
        drain_r(2);
        rst_n = 0;
        #1;
        chk("rst_mid_r_valid", err_r_valid, 1'b0);
        chk("rst_mid_cnt", cnt, 16'd0);
        exp_r.delete();
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1;
        err_r_ready = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rst_no_beats", err_r_valid, 1'b0);
        end
        ar_addr = 64'h5000_0000;
        #1;
        chk("rst_rd_idle", ar_ready, 1'b1);

        // saturation: run both error paths flat out up to near the top
        @(negedge clk);
        ar_addr = 64'h5000_0000; ar_len = 0; aw_addr = 64'h5000_0000;
        err_r_ready = 1; err_w_valid = 1; err_w_last = 1; err_b_ready = 1;
        ar_valid = 1; aw_valid = 1;
        guard = 0;
        while (cnt < 16'hFFF0 && guard < 90000) begin
            @(negedge clk);
            guard++;
        end
        ar_valid = 0; aw_valid = 0;
        if (guard >= 90000) chk("sat_burst_timeout", cnt, 16'hFFF0);
        repeat (4) @(negedge clk);
        guard = 0;
        while (cnt != 16'hFFFE && guard < 40) begin
            ar_valid = 1;
            @(negedge clk);
            ar_valid = 0;
            @(negedge clk);
            guard++;
        end
        chk("sat_pre", cnt, 16'hFFFE);
        ar_valid = 1; aw_valid = 1;
        #1;
        chk("sat_ar_ready", ar_ready, 1'b1);
        chk("sat_aw_ready", aw_ready, 1'b1);
        @(negedge clk);
        ar_valid = 0; aw_valid = 0;
        #1;
        chk("sat_both", cnt, 16'hFFFF);
        repeat (4) @(negedge clk);
        ar_valid = 1;
        @(negedge clk);
        ar_valid = 0;
        #1;
        chk("sat_hold", cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
